// File: rtl/gameover_pkg.sv
`default_nettype none
// ============================================================================
// gameover_pkg -- shared types and sizing helpers for the game-over overlay
// Rev 1.0
// ============================================================================
package gameover_pkg;

  typedef enum logic [1:0] {
    GO_IDLE   = 2'd0,
    GO_REVEAL = 2'd1,
    GO_SHOW   = 2'd2
  } go_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

  function automatic int rom_aw(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gameover_reveal_ctrl.sv
`default_nettype none
// ============================================================================
// gameover_reveal_ctrl -- frame-stepped reveal FSM (IDLE/REVEAL/SHOW) and row count
// Rev 1.0 | optional feature macro: GAMEOVER_BLINK_EN (blink phase while in SHOW)
// ============================================================================
module gameover_reveal_ctrl
  import gameover_pkg::*;
#(
  parameter int  IMG_H        = 240,
  parameter int  REVEAL_STEP  = 8,
  parameter int  BLINK_FRAMES = 32,
  localparam int RW           = $clog2(IMG_H + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trigger,
  input  logic          clear,
  input  logic          frame_start,
  output logic [RW-1:0] reveal_rows,
  output logic          active,
  output logic          visible
);

  localparam int RW1 = RW + 1;

  if (REVEAL_STEP < 1 || REVEAL_STEP > IMG_H || BLINK_FRAMES < 1) begin : g_param_check
    $error("gameover_reveal_ctrl: REVEAL_STEP or BLINK_FRAMES out of range");
  end

  go_state_t      state, state_nxt;
  logic [RW1-1:0] rows_sum;
  logic           reveal_full;
  logic           blink_on;

  assign rows_sum    = {1'b0, reveal_rows} + RW1'(REVEAL_STEP);
  assign reveal_full = rows_sum >= RW1'(IMG_H);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GO_IDLE;
    else        state <= state_nxt;
  end

  // In IDLE trigger beats clear; once active, clear beats everything else.
  always_comb begin
    state_nxt = state;
    unique case (state)
      GO_IDLE:   if (trigger) state_nxt = GO_REVEAL;
      GO_REVEAL: begin
        if (clear)                           state_nxt = GO_IDLE;
        else if (frame_start && reveal_full) state_nxt = GO_SHOW;
      end
      GO_SHOW:   if (clear) state_nxt = GO_IDLE;
      default:   state_nxt = GO_IDLE;
    endcase
  end

  always_comb begin
    active  = (state != GO_IDLE);
    visible = active && blink_on;
  end

  // Rows only advance on frame_start, so a frame is never drawn mid-step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reveal_rows <= '0;
    end else if (state == GO_IDLE) begin
      reveal_rows <= '0;
    end else if (state == GO_REVEAL && frame_start && !clear) begin
      reveal_rows <= reveal_full ? RW'(IMG_H) : rows_sum[RW-1:0];
    end
  end

`ifdef GAMEOVER_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (state != GO_SHOW) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_on = blink_phase;
`else
  assign blink_on = 1'b1;
`endif

endmodule
`default_nettype wire

// File: rtl/gameover_index_gen.sv
`default_nettype none
// ============================================================================
// gameover_index_gen -- game-over overlay: draw position -> sprite ROM -> palette index
// Rev 1.0 | optional feature macro: GAMEOVER_BLINK_EN (blink phase while in SHOW)
// ============================================================================
module gameover_index_gen
  import gameover_pkg::*;
#(
  parameter int  IMG_W        = 320,
  parameter int  IMG_H        = 240,
  parameter int  ORIGIN_X     = 160,
  parameter int  ORIGIN_Y     = 120,
  parameter int  REVEAL_STEP  = 8,
  parameter int  TRANSP_IDX   = 0,
  parameter int  BLINK_FRAMES = 32,
  localparam int ROM_AW       = rom_aw(IMG_W, IMG_H)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               trigger,
  input  logic               clear,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [3:0]         rom_q,
  output logic [3:0]         index,
  output logic               index_valid,
  output logic               overlay_on
);

  localparam int SW     = COORD_W + 1;
  localparam int RW     = $clog2(IMG_H + 1);
  localparam int W_BITS = $clog2(IMG_W + 1);

  localparam logic signed [SW-1:0] ORG_X  = SW'(ORIGIN_X);
  localparam logic signed [SW-1:0] ORG_Y  = SW'(ORIGIN_Y);
  localparam logic signed [SW-1:0] WIN_W  = SW'(IMG_W);
  localparam logic signed [SW-1:0] WIN_H  = SW'(IMG_H);
  localparam logic [3:0]           TRANSP = 4'(TRANSP_IDX);

  logic signed [SW-1:0] rx, ry;
  logic                 in_win;
  logic [ROM_AW-1:0]    row_base, addr_nxt;
  logic                 in_win_q, in_win_d;
  logic [RW-1:0]        ry_q, ry_d;
  logic [RW-1:0]        reveal_rows;
  logic                 active, visible;

  gameover_reveal_ctrl #(
    .IMG_H        (IMG_H),
    .REVEAL_STEP  (REVEAL_STEP),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_ctrl (
    .clk         (Clk),
    .rst_n       (Reset_n),
    .trigger     (trigger),
    .clear       (clear),
    .frame_start (frame_start),
    .reveal_rows (reveal_rows),
    .active      (active),
    .visible     (visible)
  );

  assign rx     = $signed({1'b0, DrawX}) - ORG_X;
  assign ry     = $signed({1'b0, DrawY}) - ORG_Y;
  assign in_win = !rx[SW-1] && !ry[SW-1] && (rx < WIN_W) && (ry < WIN_H);

  // Constant multiply by IMG_W unrolled into shifted adds of the row offset.
  always_comb begin
    row_base = '0;
    for (int b = 0; b < W_BITS; b++) begin
      if (IMG_W[b]) row_base = row_base + (ROM_AW'($unsigned(ry)) << b);
    end
    addr_nxt = in_win ? row_base + ROM_AW'($unsigned(rx)) : '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr    <= '0;
      in_win_q    <= 1'b0;
      ry_q        <= '0;
      in_win_d    <= 1'b0;
      ry_d        <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      overlay_on  <= 1'b0;
    end else begin
      rom_addr    <= addr_nxt;
      in_win_q    <= in_win;
      ry_q        <= ry[RW-1:0];
      in_win_d    <= in_win_q;
      ry_d        <= ry_q;
      index       <= rom_q;
      index_valid <= in_win_d && (ry_d < reveal_rows) && visible && (rom_q != TRANSP);
      overlay_on  <= active;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gameover_index_gen.sv
`default_nettype none
// Randomised scoreboard bench for gameover_index_gen (default build, blink disabled).
module tb_gameover_index_gen;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int OX    = 160;
  localparam int OY    = 120;
  localparam int STEP  = 8;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        trigger = 1'b0;
  logic        clear = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q = '0;
  logic [3:0]  index;
  logic        index_valid;
  logic        overlay_on;

  int total = 0;
  int bad   = 0;

  bit m_active = 1'b0;
  int m_rows   = 0;

  bit       px_en = 1'b0;
  bit [2:0] tag   = '0;
  int         exp_addr_q[$];
  logic [4:0] exp_px_q[$];

  gameover_index_gen dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .trigger     (trigger),
    .clear       (clear),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .index       (index),
    .index_valid (index_valid),
    .overlay_on  (overlay_on)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_fn(input int a);
    return 4'((a ^ (a >> 4) ^ (a >> 9) ^ (a * 3)) & 15);
  endfunction

  always @(posedge Clk) rom_q <= rom_fn(int'(rom_addr));
  always @(posedge Clk) tag <= {tag[1:0], px_en};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Monitor: address one edge after the pixel, index/valid three edges after.
  always @(negedge Clk) begin
    logic [4:0] e;
    if (tag[0]) begin
      if (exp_addr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL addr_scoreboard: got output with no expectation queued");
      end else begin
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr_q.pop_front()));
      end
    end
    if (tag[2]) begin
      if (exp_px_q.size() == 0) begin
        total++; bad++;
        $display("FAIL px_scoreboard: got output with no expectation queued");
      end else begin
        e = exp_px_q.pop_front();
        chk("index", 32'(index), 32'(e[3:0]));
        chk("index_valid", 32'(index_valid), 32'(e[4]));
      end
    end
  end

  task automatic send_px(input int x, input int y);
    int rx, ry, a;
    bit inw, v;
    logic [3:0] q;
    rx  = x - OX;
    ry  = y - OY;
    inw = (rx >= 0) && (rx < IMG_W) && (ry >= 0) && (ry < IMG_H);
    a   = inw ? ry * IMG_W + rx : 0;
    q   = rom_fn(a);
    v   = inw && (ry < m_rows) && m_active && (q != 4'd0);
    exp_addr_q.push_back(a);
    exp_px_q.push_back({v, q});
    DrawX = 10'(x);
    DrawY = 10'(y);
    px_en = 1'b1;
    @(negedge Clk);
  endtask

  task automatic drain();
    px_en = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic pulse(input bit t, input bit c, input bit f);
    trigger = t; clear = c; frame_start = f;
    if (t && !m_active) begin
      m_active = 1'b1;
      m_rows   = 0;
    end else if (c && m_active) begin
      m_active = 1'b0;
    end else if (f && m_active) begin
      m_rows = (m_rows + STEP > IMG_H) ? IMG_H : m_rows + STEP;
    end
    @(negedge Clk);
    trigger = 1'b0; clear = 1'b0; frame_start = 1'b0;
  endtask

  task automatic rand_burst(input int n);
    for (int i = 0; i < n; i++) begin
      int x, y;
      x = $urandom_range(500, 140);
      y = $urandom_range(380, 100);
      if ($urandom_range(7, 0) == 0) begin
        case ($urandom_range(3, 0))
          0: x = OX - 1;
          1: x = OX;
          2: x = OX + IMG_W - 1;
          default: x = OX + IMG_W;
        endcase
      end
      if ($urandom_range(7, 0) == 0) y = ($urandom_range(1, 0) == 1) ? OY + IMG_H - 1 : OY + IMG_H;
      send_px(x, y);
    end
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tagname, "_index"}, 32'(index), 32'd0);
    chk({tagname, "_index_valid"}, 32'(index_valid), 32'd0);
    chk({tagname, "_overlay_on"}, 32'(overlay_on), 32'd0);
  endtask

  initial begin
    #500000;
    total++; bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int park_x;
    bit park_v;

    repeat (3) @(negedge Clk);
    chk_reset_outputs("reset");
    Reset_n = 1'b1;
    @(negedge Clk);

    // Window edges and corner addresses while idle.
    send_px(160, 120); send_px(479, 359); send_px(159, 120); send_px(480, 200);
    send_px(300, 119); send_px(300, 360); send_px(0, 0);     send_px(639, 479);
    drain();
    chk("overlay_idle", 32'(overlay_on), 32'(m_active));

    // trigger and clear together in IDLE enter REVEAL.
    pulse(1'b1, 1'b1, 1'b0);
    drain();
    chk("overlay_trig_clr", 32'(overlay_on), 32'(m_active));

    pulse(1'b0, 1'b0, 1'b1);
    for (int x = 160; x < 176; x++) begin
      send_px(x, OY + 7);
      send_px(x, OY + 8);
    end
    drain();

    repeat (28) pulse(1'b0, 1'b0, 1'b1);
    for (int x = 200; x < 216; x++) begin
      send_px(x, OY + 231);
      send_px(x, OY + 232);
    end
    drain();

    pulse(1'b0, 1'b0, 1'b1);
    for (int x = 200; x < 216; x++) begin
      send_px(x, OY + 239);
      send_px(x, OY + 240);
    end
    rand_burst(200);
    drain();
    chk("overlay_show", 32'(overlay_on), 32'(m_active));

    // Clear in SHOW: the very next pixels lose their valid.
    pulse(1'b0, 1'b1, 1'b0);
    for (int x = 200; x < 216; x++) send_px(x, OY + 239);
    drain();
    chk("overlay_cleared", 32'(overlay_on), 32'(m_active));

    // Asynchronous reset in the middle of REVEAL with 64 rows shown.
    pulse(1'b1, 1'b0, 1'b0);
    repeat (8) pulse(1'b0, 1'b0, 1'b1);
    park_x = 0;
    for (int k = 0; k < IMG_W; k++) begin
      if (rom_fn(20 * IMG_W + k) != 4'd0) begin
        park_x = k;
        break;
      end
    end
    park_v = m_active && (20 < m_rows) && (rom_fn(20 * IMG_W + park_x) != 4'd0);
    DrawX = 10'(OX + park_x);
    DrawY = 10'(OY + 20);
    px_en = 1'b0;
    repeat (4) @(negedge Clk);
    chk("pre_reset_valid", 32'(index_valid), 32'(park_v));
    #2 Reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    m_active = 1'b0;
    m_rows   = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    send_px(OX + park_x, OY + 20);
    drain();
    chk("overlay_after_reset", 32'(overlay_on), 32'(m_active));

    // Random control sequences interleaved with random pixel bursts.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(5, 0))
        0: pulse(1'b1, 1'b0, 1'b0);
        1: pulse(1'b0, 1'b1, 1'b0);
        2: pulse(1'b1, 1'b1, 1'b0);
        default: repeat ($urandom_range(12, 1)) pulse(1'b0, 1'b0, 1'b1);
      endcase
      rand_burst($urandom_range(30, 5));
      drain();
      chk("overlay_rand", 32'(overlay_on), 32'(m_active));
    end

    chk("addr_queue_left", 32'(exp_addr_q.size()), 32'd0);
    chk("px_queue_left", 32'(exp_px_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
